// File: rtl/cond_check.sv
// -----------------------------------------------------------------------------
// cond_check
//
// Condition-check stage between issue and writeback. It holds the NZCV status
// register and counts the flag-setting instructions that have issued but whose
// ALU flag write has not yet arrived. Each request's 4-bit condition code is
// evaluated against the effective flags. The result is a registered
// execute/squash decision, returned over a valid/ready handshake.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   flags_we     in   ALU flag write strobe
//   flags_in     in   {N,Z,C,V} from the ALU, valid with flags_we
//   pend_set     in   one more flag-setting instruction is now in flight
//   instr_valid  in   condition-check request valid
//   instr_ready  out  request accepted when instr_valid && instr_ready
//   instr_cond   in   condition code (EQ..NV)
//   instr_tag    in   opaque tag carried to the decision
//   out_valid    out  decision valid
//   out_ready    in   downstream accepts the decision
//   out_exec     out  1 = execute, 0 = squash
//   out_tag      out  tag of the decided instruction
//   nzcv         out  architectural status register
//   pend_full    out  in-flight counter at its maximum
//   err          out  sticky: pend_set seen while the counter was full
// -----------------------------------------------------------------------------
module cond_check #(
   parameter int PEND_W = 3,
   parameter int TAG_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flags_we,
   input  logic [3:0]       flags_in,
   input  logic             pend_set,
   input  logic             instr_valid,
   output logic             instr_ready,
   input  logic [3:0]       instr_cond,
   input  logic [TAG_W-1:0] instr_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_exec,
   output logic [TAG_W-1:0] out_tag,
   output logic [3:0]       nzcv,
   output logic             pend_full,
   output logic             err
);

   localparam logic [PEND_W-1:0] PEND_MAX = '1;
   localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

   logic [3:0]        nzcv_q, nzcv_d;
   logic [PEND_W-1:0] pend_cnt_q, pend_cnt_d;
   logic              err_q, err_d;
   logic              out_valid_q, out_valid_d;
   logic              out_exec_q, out_exec_d;
   logic [TAG_W-1:0]  out_tag_q, out_tag_d;

   logic [3:0] eff;
   logic       f_n, f_z, f_c, f_v;
   logic       cond_res;
   logic       flags_safe;
   logic       accept;

   // A flag write in the same cycle is visible to the condition immediately.
   assign eff = flags_we ? flags_in : nzcv_q;
   assign f_n = eff[3];
   assign f_z = eff[2];
   assign f_c = eff[1];
   assign f_v = eff[0];

   always_comb begin
      cond_res = 1'b0;
      case (instr_cond)
         4'h0: cond_res = f_z;
         4'h1: cond_res = !f_z;
         4'h2: cond_res = f_c;
         4'h3: cond_res = !f_c;
         4'h4: cond_res = f_n;
         4'h5: cond_res = !f_n;
         4'h6: cond_res = f_v;
         4'h7: cond_res = !f_v;
         4'h8: cond_res = f_c && !f_z;
         4'h9: cond_res = !f_c || f_z;
         4'hA: cond_res = (f_n == f_v);
         4'hB: cond_res = (f_n != f_v);
         4'hC: cond_res = !f_z && (f_n == f_v);
         4'hD: cond_res = f_z || (f_n != f_v);
         4'hE: cond_res = 1'b1;
         default: cond_res = 1'b0;
      endcase
   end

   // The flags are final when nothing is in flight, or when the last
   // outstanding write lands this cycle. AL and NV ignore the flags entirely.
   assign flags_safe = (pend_cnt_q == '0)
                    || ((pend_cnt_q == PEND_ONE) && flags_we)
                    || (instr_cond[3:1] == 3'b111);

   // Depends only on state, flags_we, instr_cond and out_ready, never on instr_valid.
   assign instr_ready = flags_safe && (!out_valid_q || out_ready);
   assign accept      = instr_valid && instr_ready;

   always_comb begin
      nzcv_d      = nzcv_q;
      pend_cnt_d  = pend_cnt_q;
      err_d       = err_q;
      out_valid_d = out_valid_q;
      out_exec_d  = out_exec_q;
      out_tag_d   = out_tag_q;

      if (flags_we) begin
         nzcv_d = flags_in;
      end

      // A set and a retire in the same cycle cancel. An unannounced write
      // at zero leaves the count at zero.
      case ({pend_set, flags_we})
         2'b10: begin
            if (pend_cnt_q == PEND_MAX) begin
               err_d = 1'b1;
            end else begin
               pend_cnt_d = pend_cnt_q + PEND_ONE;
            end
         end
         2'b01: begin
            if (pend_cnt_q != '0) begin
               pend_cnt_d = pend_cnt_q - PEND_ONE;
            end
         end
         default: pend_cnt_d = pend_cnt_q;
      endcase

      if (accept) begin
         out_valid_d = 1'b1;
         out_exec_d  = cond_res;
         out_tag_d   = instr_tag;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         nzcv_q      <= 4'b0000;
         pend_cnt_q  <= '0;
         err_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_exec_q  <= 1'b0;
         out_tag_q   <= '0;
      end else begin
         nzcv_q      <= nzcv_d;
         pend_cnt_q  <= pend_cnt_d;
         err_q       <= err_d;
         out_valid_q <= out_valid_d;
         out_exec_q  <= out_exec_d;
         out_tag_q   <= out_tag_d;
      end
   end

   assign nzcv      = nzcv_q;
   assign pend_full = (pend_cnt_q == PEND_MAX);
   assign err       = err_q;
   assign out_valid = out_valid_q;
   assign out_exec  = out_exec_q;
   assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_cond_check.sv
// -----------------------------------------------------------------------------
// tb_cond_check
//
// Directed bench for cond_check. The stimulus pushes each expected decision
// {exec, tag} into a queue. A monitor on the falling edge pops the queue and
// compares it whenever a decision is handed off (out_valid && out_ready).
// Status outputs are checked inline against hand-computed constants.
// -----------------------------------------------------------------------------
module tb_cond_check;

   logic       clk = 1'b0;
   logic       rst;
   logic       flags_we;
   logic [3:0] flags_in;
   logic       pend_set;
   logic       instr_valid;
   logic       instr_ready;
   logic [3:0] instr_cond;
   logic [7:0] instr_tag;
   logic       out_valid;
   logic       out_ready;
   logic       out_exec;
   logic [7:0] out_tag;
   logic [3:0] nzcv;
   logic       pend_full;
   logic       err;

   typedef struct packed {
      logic       exec;
      logic [7:0] tag;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   cond_check #(.PEND_W(3), .TAG_W(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .flags_we    (flags_we),
      .flags_in    (flags_in),
      .pend_set    (pend_set),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr_cond  (instr_cond),
      .instr_tag   (instr_tag),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_exec    (out_exec),
      .out_tag     (out_tag),
      .nzcv        (nzcv),
      .pend_full   (pend_full),
      .err         (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      flags_we    = 1'b0;
      pend_set    = 1'b0;
      instr_valid = 1'b0;
   endtask

   // Monitor: one line per completed decision, compared against the queue head.
   always @(negedge clk) begin
      exp_t e;
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected decision: got tag=%0h exec=%0b, want none", out_tag, out_exec);
         end else begin
            e = sb.pop_front();
            $display("decision tag=%0h exec=%0b (want tag=%0h exec=%0b)", out_tag, out_exec, e.tag, e.exec);
            chk("decision exec", {31'd0, out_exec}, {31'd0, e.exec});
            chk("decision tag", {24'd0, out_tag}, {24'd0, e.tag});
         end
      end
   end

   // Load flags, then present all 16 condition codes back to back.
   // tbl[i] is the hand-computed result for cond i.
   task automatic sweep(input logic [3:0] f, input logic [15:0] tbl, input logic [7:0] base);
      flags_we = 1'b1;
      flags_in = f;
      tick();
      flags_we = 1'b0;
      for (int i = 0; i < 16; i++) begin
         instr_valid = 1'b1;
         instr_cond  = 4'(i);
         instr_tag   = base + 8'(i);
         sb.push_back({tbl[i], instr_tag});
         @(negedge clk);
         if (i == 0) chk("sweep nzcv", {28'd0, nzcv}, {28'd0, f});
         chk("sweep ready", {31'd0, instr_ready}, 32'd1);
         tick();
      end
      idle();
      tick();
   endtask

   initial begin
      rst         = 1'b1;
      flags_we    = 1'b0;
      flags_in    = 4'b0000;
      pend_set    = 1'b0;
      instr_valid = 1'b0;
      instr_cond  = 4'h0;
      instr_tag   = 8'h00;
      out_ready   = 1'b1;
      tick();
      tick();

      // Reset state
      @(negedge clk);
      chk("reset nzcv", {28'd0, nzcv}, 32'd0);
      chk("reset pend_full", {31'd0, pend_full}, 32'd0);
      chk("reset err", {31'd0, err}, 32'd0);
      chk("reset out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset out_exec", {31'd0, out_exec}, 32'd0);
      chk("reset out_tag", {24'd0, out_tag}, 32'd0);
      chk("reset instr_ready", {31'd0, instr_ready}, 32'd1);
      tick();
      rst = 1'b0;

      // Flag write with EQ accepted in the same cycle (bypass)
      flags_we    = 1'b1;
      flags_in    = 4'b0100;
      instr_valid = 1'b1;
      instr_cond  = 4'h0;
      instr_tag   = 8'h10;
      sb.push_back({1'b1, 8'h10});
      @(negedge clk);
      chk("bypass ready", {31'd0, instr_ready}, 32'd1);
      tick();
      idle();
      @(negedge clk);
      chk("bypass nzcv", {28'd0, nzcv}, 32'h4);
      chk("bypass out_valid", {31'd0, out_valid}, 32'd1);
      tick();

      // Full condition table on two flag patterns
      sweep(4'b1001, 16'h565A, 8'h20);
      sweep(4'b0110, 16'h66A5, 8'h30);

      // Two writes pending: stall until the final write, AL passes at once
      pend_set = 1'b1;
      tick();
      tick();
      pend_set    = 1'b0;
      instr_valid = 1'b1;
      instr_cond  = 4'h1;
      instr_tag   = 8'h40;
      @(negedge clk);
      chk("stall cnt2 ready", {31'd0, instr_ready}, 32'd0);
      tick();
      instr_cond = 4'hE;
      instr_tag  = 8'h41;
      sb.push_back({1'b1, 8'h41});
      @(negedge clk);
      chk("AL while pending ready", {31'd0, instr_ready}, 32'd1);
      tick();
      instr_cond = 4'h1;
      instr_tag  = 8'h40;
      flags_we   = 1'b1;
      flags_in   = 4'b1111;
      @(negedge clk);
      chk("stall first write ready", {31'd0, instr_ready}, 32'd0);
      tick();
      flags_in = 4'b0000;
      sb.push_back({1'b1, 8'h40});
      @(negedge clk);
      chk("final write ready", {31'd0, instr_ready}, 32'd1);
      tick();
      idle();
      tick();

      // Back-pressure: decision held for 3 cycles, then released
      instr_valid = 1'b1;
      instr_cond  = 4'hF;
      instr_tag   = 8'h50;
      sb.push_back({1'b0, 8'h50});
      tick();
      instr_cond = 4'hE;
      instr_tag  = 8'h51;
      out_ready  = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("hold out_valid", {31'd0, out_valid}, 32'd1);
         chk("hold out_exec", {31'd0, out_exec}, 32'd0);
         chk("hold out_tag", {24'd0, out_tag}, 32'h50);
         chk("hold instr_ready", {31'd0, instr_ready}, 32'd0);
         tick();
      end
      out_ready = 1'b1;
      sb.push_back({1'b1, 8'h51});
      @(negedge clk);
      chk("release ready", {31'd0, instr_ready}, 32'd1);
      tick();
      idle();
      tick();

      // Counter: set+write cancel at 3, saturate at 7, overflow sets err
      pend_set = 1'b1;
      tick();
      tick();
      tick();
      flags_we = 1'b1;
      flags_in = 4'b0000;
      tick();
      flags_we = 1'b0;
      tick();
      tick();
      tick();
      instr_cond = 4'h0;
      @(negedge clk);
      chk("cnt6 pend_full", {31'd0, pend_full}, 32'd0);
      chk("cnt6 ready", {31'd0, instr_ready}, 32'd0);
      tick();
      @(negedge clk);
      chk("cnt7 pend_full", {31'd0, pend_full}, 32'd1);
      chk("cnt7 err", {31'd0, err}, 32'd0);
      tick();
      pend_set = 1'b0;
      @(negedge clk);
      chk("overflow err", {31'd0, err}, 32'd1);
      chk("overflow pend_full", {31'd0, pend_full}, 32'd1);

      // Drain 7 -> 1, then the last write coincides with the accept
      flags_we = 1'b1;
      flags_in = 4'b0100;
      for (int k = 0; k < 6; k++) tick();
      flags_we    = 1'b0;
      instr_valid = 1'b1;
      instr_cond  = 4'h0;
      instr_tag   = 8'h60;
      @(negedge clk);
      chk("cnt1 no write ready", {31'd0, instr_ready}, 32'd0);
      chk("cnt1 pend_full", {31'd0, pend_full}, 32'd0);
      tick();
      flags_we = 1'b1;
      sb.push_back({1'b1, 8'h60});
      @(negedge clk);
      chk("cnt1 with write ready", {31'd0, instr_ready}, 32'd1);
      tick();
      idle();
      @(negedge clk);
      chk("cnt0 ready", {31'd0, instr_ready}, 32'd1);
      chk("err sticky", {31'd0, err}, 32'd1);
      tick();

      // Reset mid-operation: pending count 2, decision in flight
      pend_set = 1'b1;
      tick();
      tick();
      pend_set    = 1'b0;
      out_ready   = 1'b0;
      instr_valid = 1'b1;
      instr_cond  = 4'hE;
      instr_tag   = 8'h70;
      tick();
      idle();
      instr_cond = 4'h0;
      @(negedge clk);
      chk("pre-reset out_valid", {31'd0, out_valid}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("rst nzcv", {28'd0, nzcv}, 32'd0);
      chk("rst pend_full", {31'd0, pend_full}, 32'd0);
      chk("rst err", {31'd0, err}, 32'd0);
      chk("rst out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst out_exec", {31'd0, out_exec}, 32'd0);
      chk("rst out_tag", {24'd0, out_tag}, 32'd0);
      chk("rst instr_ready", {31'd0, instr_ready}, 32'd1);
      tick();
      rst       = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("post-reset ready", {31'd0, instr_ready}, 32'd1);
      tick();
      tick();

      chk("scoreboard drained", sb.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cond_check.md
# cond_check

Condition-check stage that consumes the ALU's NZCV flag stream. It holds the architectural NZCV status register, tracks flag-setting instructions still in flight, and evaluates each issued instruction's 4-bit condition field against the current flags. It sits between issue and writeback and produces a registered execute/squash decision per instruction over a valid/ready handshake.

## Interface
- PEND_W, 3: width of the outstanding-flag-write counter; maximum in-flight count is 2^PEND_W-1.
- TAG_W, 8: width of the instruction tag carried alongside the decision.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flags_we  in  1  ALU flag write strobe; asserted when the S bit is set and the opcode is not NOP.
- flags_in  in  4  {N,Z,C,V} from the ALU; valid when flags_we=1.
- pend_set  in  1  issue has launched one flag-setting instruction; its flags_we arrives later.
- instr_valid  in  1  condition-check request valid.
- instr_ready  out  1  request accepted when instr_valid && instr_ready.
- instr_cond  in  4  condition code.
- instr_tag  in  TAG_W  opaque tag.
- out_valid  out  1  decision valid.
- out_ready  in  1  downstream accepts the decision.
- out_exec  out  1  1 = execute, 0 = squash.
- out_tag  out  TAG_W  tag of the decided instruction.
- nzcv  out  4  current status register.
- pend_full  out  1  counter at maximum.
- err  out  1  sticky; pend_set was asserted while pend_full.

## Operation
- Effective flags: eff = flags_we ? flags_in : nzcv (same-cycle bypass).
- nzcv <= flags_in on every clk with flags_we=1, regardless of the counter.
- Pending counter pend_cnt:
  - pend_set only: +1. flags_we only: -1.
  - Both in the same cycle: unchanged.
  - flags_we at 0: stays 0 (unannounced write, still updates nzcv).
  - pend_set at max without flags_we: ignored, err <= 1; err cleared only by rst.
- Conditions on eff:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V)
  - E AL 1; F NV 0
- Flags-safe: pend_cnt==0, or pend_cnt==1 && flags_we, or instr_cond in {E,F}.
- instr_ready = flags-safe && (!out_valid || out_ready). instr_ready must not depend on instr_valid.
- On accept: out_exec <= cond result, out_tag <= instr_tag, out_valid <= 1.
- Otherwise, if out_ready: out_valid <= 0.
- out_exec and out_tag hold stable while out_valid && !out_ready.

## Timing
- Reset values: nzcv=0000, pend_cnt=0, pend_full=0, err=0, out_valid=0, out_exec=0, out_tag=0. instr_ready then follows combinationally (1 out of reset for any cond).
- Latency: 1 cycle from accept to out_valid; back-to-back accepts at 1/cycle while out_ready=1.
- Flag write to dependent decision: 0 extra cycles when the final flags_we and the accept coincide (bypass); nzcv output updates the cycle after.
- Stall: while pend_cnt≥2, or pend_cnt==1 without flags_we, instr_ready=0 for cond 0–D.
- rst mid-operation: all state returns to reset values immediately; an in-flight decision is discarded.

## Test plan
- Reset then flags_we=1, flags_in=0100, with instr cond=0 (EQ) accepted the same cycle: next cycle out_valid=1, out_exec=1; nzcv=0100.
- nzcv=1001 (N=1,V=1), sweep all 16 conds back-to-back with out_ready=1: out_exec follows the table (GE=1, LT=0, GT=1, LE=0, NV=0), one decision per cycle.
- pend_set twice, cond=1 presented: instr_ready=0. First flags_we: still 0. Second flags_we with 0000: instr_ready=1 that cycle, out_exec=1. Cond=E while pending: accepted immediately.
- out_ready held 0 for 3 cycles after a decision: out_valid/out_exec/out_tag stable, instr_ready=0; release: next request accepted the same cycle.
- pend_set and flags_we together at pend_cnt=3: count stays 3. pend_set ×4 more: pend_full=1 at 7, 8th pend_set sets err=1, count stays 7.
- Assert rst while pend_cnt=2 and out_valid=1: all outputs return to reset values before the next edge.
